nmr_voter_seq: RTL and testbench

- Parametrised, stateful successor to the combinational TMR voter.
- Votes N redundant core-output lanes at word level, tracks per-lane disagreement history, and permanently masks a lane after FAULT_THRESH consecutive mismatches.
- Reports the redundancy health state; requests a resync when a lane is dropped.
- Sits between the replicated cores and the shared instruction/data memories.

---
 rtl/nmr_voter_pkg.sv | 28 ++
 rtl/nmr_lane_tracker.sv | 64 ++++++
 rtl/nmr_voter_seq.sv | 126 ++++++++++++
 tb/tb_nmr_voter_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/nmr_voter_pkg.sv
// Shared types for the N-modular redundancy voter: health encodings, lane word layout, stats width.
// Pure declarations; no latency or backpressure.
package nmr_voter_pkg;

  typedef enum logic [1:0] {
    ST_FULL     = 2'b00,
    ST_DEGRADED = 2'b01,
    ST_DUAL     = 2'b10,
    ST_FAILED   = 2'b11
  } health_e;

  // Default 97-bit lane word, MSB first: PC, ALUResult, RD2, MemWrite.
  localparam int PC_LSB       = 65;
  localparam int ALU_LSB      = 33;
  localparam int RD2_LSB      = 1;
  localparam int MEMWRITE_BIT = 0;
  localparam int FIELD_W      = 32;

  typedef struct packed {
    logic [FIELD_W-1:0] pc;
    logic [FIELD_W-1:0] alu_result;
    logic [FIELD_W-1:0] rd2;
    logic               mem_write;
  } core_word_t;

  localparam int STATS_W = 16;

endpackage

// File: rtl/nmr_lane_tracker.sv
// Per-lane consecutive-mismatch counter and sticky mask; mask_nxt exposes the value the next edge loads.
// Mask asserts on the edge ending the FAULT_THRESH-th consecutive mismatch; no backpressure.
module nmr_lane_tracker
  import nmr_voter_pkg::*;
#(
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic upd,
  input  logic mismatch,
  output logic mask,
  output logic mask_nxt
`ifdef NMR_VOTER_STATS_EN
  ,
  output logic [STATS_W-1:0] err_cnt
`endif
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(FAULT_THRESH);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt  = cnt;
    mask_nxt = mask;
    if (clear) begin
      cnt_nxt  = '0;
      mask_nxt = 1'b0;
    end else if (upd && !mask) begin
      if (mismatch) begin
        if (cnt < THRESH) cnt_nxt = cnt + 1'b1;
        if (cnt_nxt >= THRESH) mask_nxt = 1'b1;
      end else begin
        cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      mask <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      mask <= mask_nxt;
    end
  end

`ifdef NMR_VOTER_STATS_EN
  // Cumulative count survives clear; only reset wipes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (upd && !mask && mismatch && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/nmr_voter_seq.sv
// Word-level N-lane majority voter with fault masking and health state; NMR_VOTER_STATS_EN adds err_cnt_o.
// Vote is combinational (0 cycles); mask/state/resync update 1 cycle after the deciding valid cycle; no backpressure.
module nmr_voter_seq
  import nmr_voter_pkg::*;
#(
  parameter int N_LANES      = 3,
  parameter int DATA_W       = 97,
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_i,
  input  logic                        clear_i,
  input  logic [N_LANES*DATA_W-1:0]   lanes_i,
  output logic [DATA_W-1:0]           voted_o,
  output logic [N_LANES-1:0]          mismatch_o,
  output logic                        no_majority_o,
  output logic [N_LANES-1:0]          mask_o,
  output logic [1:0]                  state_o,
  output logic                        resync_req_o
`ifdef NMR_VOTER_STATS_EN
  ,
  output logic [N_LANES*STATS_W-1:0]  err_cnt_o
`endif
);

  // One spare bit so twice the agreement count never overflows.
  localparam int CW = $clog2(N_LANES + 1) + 1;

  logic [DATA_W-1:0]  word [N_LANES];
  logic [N_LANES-1:0] mask_nxt;
  logic [CW-1:0]      n_active;
  logic [CW-1:0]      n_active_nxt;
  logic [CW-1:0]      agree;
  logic               have_maj;
  logic [DATA_W-1:0]  maj_word;
  logic [DATA_W-1:0]  first_word;
  logic               upd;
  health_e            state_q;

  always_comb begin
    n_active = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (!mask_o[i]) n_active = n_active + 1'b1;
    end
  end

  // Scan high-to-low so the lowest-index holder of each word wins.
  always_comb begin
    have_maj   = 1'b0;
    maj_word   = '0;
    first_word = '0;
    agree      = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (!mask_o[i]) begin
        agree = '0;
        for (int j = 0; j < N_LANES; j++) begin
          if (!mask_o[j] && (word[j] == word[i])) agree = agree + 1'b1;
        end
        if ((agree << 1) > n_active) begin
          have_maj = 1'b1;
          maj_word = word[i];
        end
        first_word = word[i];
      end
    end
  end

  always_comb begin
    mismatch_o = '0;
    for (int j = 0; j < N_LANES; j++) begin
      mismatch_o[j] = !rst && have_maj && !mask_o[j] && (word[j] != maj_word);
    end
  end

  assign voted_o       = have_maj ? maj_word : first_word;
  assign no_majority_o = !rst && !have_maj;
  assign upd           = valid_i && have_maj && !rst && !clear_i;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    assign word[g] = lanes_i[g*DATA_W +: DATA_W];

    nmr_lane_tracker #(
      .FAULT_THRESH (FAULT_THRESH),
      .CNT_W        (CNT_W)
    ) u_trk (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear_i),
      .upd      (upd),
      .mismatch (mismatch_o[g]),
      .mask     (mask_o[g]),
      .mask_nxt (mask_nxt[g])
`ifdef NMR_VOTER_STATS_EN
      ,
      .err_cnt  (err_cnt_o[g*STATS_W +: STATS_W])
`endif
    );
  end

  always_comb begin
    n_active_nxt = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (!mask_nxt[i]) n_active_nxt = n_active_nxt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FULL;
      resync_req_o <= 1'b0;
    end else begin
      resync_req_o <= |(mask_nxt & ~mask_o);
      if (clear_i)                       state_q <= ST_FULL;
      else if (state_q == ST_FAILED)     state_q <= ST_FAILED;
      else if (valid_i && !have_maj)     state_q <= ST_FAILED;
      else if (n_active_nxt == CW'(N_LANES)) state_q <= ST_FULL;
      else if (n_active_nxt >= CW'(3))   state_q <= ST_DEGRADED;
      else                               state_q <= ST_DUAL;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_nmr_voter_seq.sv
// Scoreboard bench: directed steps push hand-computed expectations; a negedge monitor pops and compares.
module tb_nmr_voter_seq;

  localparam int W = 97;
  localparam logic [1:0] FULL = 2'b00, DEG = 2'b01, DUAL = 2'b10, FLD = 2'b11;
  localparam logic [W-1:0] A = 97'h1234, B = 97'h5678, C = 97'h9abc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           v3, c3, v5, c5;
  logic [3*W-1:0] l3;
  logic [5*W-1:0] l5;
  logic [W-1:0]   voted3, voted5;
  logic [2:0]     mism3, mask3;
  logic [4:0]     mism5, mask5;
  logic           nm3, nm5, res3, res5;
  logic [1:0]     st3, st5;
`ifdef NMR_VOTER_STATS_EN
  logic [3*16-1:0] err3;
  logic [5*16-1:0] err5;
`endif

  nmr_voter_seq #(.N_LANES(3)) u3 (
    .clk(clk), .rst(rst), .valid_i(v3), .clear_i(c3), .lanes_i(l3),
    .voted_o(voted3), .mismatch_o(mism3), .no_majority_o(nm3),
    .mask_o(mask3), .state_o(st3), .resync_req_o(res3)
`ifdef NMR_VOTER_STATS_EN
    , .err_cnt_o(err3)
`endif
  );

  nmr_voter_seq #(.N_LANES(5)) u5 (
    .clk(clk), .rst(rst), .valid_i(v5), .clear_i(c5), .lanes_i(l5),
    .voted_o(voted5), .mismatch_o(mism5), .no_majority_o(nm5),
    .mask_o(mask5), .state_o(st5), .resync_req_o(res5)
`ifdef NMR_VOTER_STATS_EN
    , .err_cnt_o(err5)
`endif
  );

  typedef struct {
    int         cyc;
    bit         d5;
    logic [W-1:0] voted;
    logic [4:0] mism;
    logic       nm;
    logic [4:0] mask;
    logic [1:0] st;
    logic       res;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, cyc, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc != cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stale_entry cycle %0d: got entry for cycle %0d, expected %0d", cyc, e.cyc, cyc);
      end else if (e.d5) begin
        check("n5.voted",    voted5,     e.voted);
        check("n5.mismatch", W'(mism5),  W'(e.mism));
        check("n5.no_maj",   W'(nm5),    W'(e.nm));
        check("n5.mask",     W'(mask5),  W'(e.mask));
        check("n5.state",    W'(st5),    W'(e.st));
        check("n5.resync",   W'(res5),   W'(e.res));
      end else begin
        check("n3.voted",    voted3,     e.voted);
        check("n3.mismatch", W'(mism3),  W'(e.mism));
        check("n3.no_maj",   W'(nm3),    W'(e.nm));
        check("n3.mask",     W'(mask3),  W'(e.mask));
        check("n3.state",    W'(st3),    W'(e.st));
        check("n3.resync",   W'(res3),   W'(e.res));
      end
    end
  end

  task automatic step3(input logic r, input logic v, input logic c,
                       input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2,
                       input logic [W-1:0] ev, input logic [2:0] em, input logic enm,
                       input logic [2:0] emask, input logic [1:0] est, input logic eres);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; v3 = v; c3 = c;
    l3  = {w2, w1, w0};
    x.cyc = cyc; x.d5 = 1'b0; x.voted = ev; x.mism = {2'b00, em}; x.nm = enm;
    x.mask = {2'b00, emask}; x.st = est; x.res = eres;
    q.push_back(x);
  endtask

  task automatic step5(input logic v, input logic c,
                       input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2,
                       input logic [W-1:0] w3, input logic [W-1:0] w4,
                       input logic [W-1:0] ev, input logic [4:0] em, input logic enm,
                       input logic [4:0] emask, input logic [1:0] est, input logic eres);
    exp_t x;
    @(posedge clk);
    #1;
    v5 = v; c5 = c;
    l5 = {w4, w3, w2, w1, w0};
    x.cyc = cyc; x.d5 = 1'b1; x.voted = ev; x.mism = em; x.nm = enm;
    x.mask = emask; x.st = est; x.res = eres;
    q.push_back(x);
  endtask

  initial begin
    rst = 1'b1; v3 = 1'b0; c3 = 1'b0; l3 = '0;
    v5 = 1'b0; c5 = 1'b0; l5 = '0;
    repeat (2) @(posedge clk);

    // Reset held with disagreeing lanes: flags suppressed, registers at reset values.
    step3(1, 1, 0, A, B, C, A, 3'b000, 0, 3'b000, FULL, 0);
    for (int i = 0; i < 10; i++) step3(0, 1, 0, A, A, A, A, 3'b000, 0, 3'b000, FULL, 0);

    // Lane 1 faulty for four valid cycles: masked, single pulse, two lanes left.
    for (int i = 0; i < 4; i++) step3(0, 1, 0, A, B, A, A, 3'b010, 0, 3'b000, FULL, 0);
    step3(0, 1, 0, A, A, A, A, 3'b000, 0, 3'b010, DUAL, 1);
    step3(0, 1, 0, A, A, A, A, 3'b000, 0, 3'b010, DUAL, 0);

    // Dual split: no majority, lane 0 forwarded, FAILED sticks until clear.
    step3(0, 1, 0, A, A, B, A, 3'b000, 1, 3'b010, DUAL, 0);
    step3(0, 1, 0, A, A, A, A, 3'b000, 0, 3'b010, FLD, 0);
    step3(0, 0, 0, A, A, A, A, 3'b000, 0, 3'b010, FLD, 0);
    step3(0, 1, 1, A, B, A, A, 3'b000, 0, 3'b010, FLD, 0);
    step3(0, 0, 0, A, A, A, A, 3'b000, 0, 3'b000, FULL, 0);

    // Lane 2: three misses, one agree, three misses -> never masked.
    for (int i = 0; i < 3; i++) step3(0, 1, 0, A, A, C, A, 3'b100, 0, 3'b000, FULL, 0);
    step3(0, 1, 0, A, A, A, A, 3'b000, 0, 3'b000, FULL, 0);
    for (int i = 0; i < 3; i++) step3(0, 1, 0, A, A, C, A, 3'b100, 0, 3'b000, FULL, 0);
    // Invalid cycle still votes but must not advance the counter sitting at 3.
    step3(0, 0, 0, A, A, C, A, 3'b100, 0, 3'b000, FULL, 0);
    step3(0, 0, 0, A, A, A, A, 3'b000, 0, 3'b000, FULL, 0);

    // Clear together with the would-be threshold mismatch: no mask.
    step3(0, 1, 1, A, A, C, A, 3'b100, 0, 3'b000, FULL, 0);
    step3(0, 1, 0, A, A, A, A, 3'b000, 0, 3'b000, FULL, 0);

    // Reset mid-count, then a full four misses are needed again.
    for (int i = 0; i < 2; i++) step3(0, 1, 0, A, A, C, A, 3'b100, 0, 3'b000, FULL, 0);
    step3(1, 1, 0, A, A, C, A, 3'b000, 0, 3'b000, FULL, 0);
    for (int i = 0; i < 4; i++) step3(0, 1, 0, A, A, C, A, 3'b100, 0, 3'b000, FULL, 0);
    step3(0, 0, 0, A, A, A, A, 3'b000, 0, 3'b100, DUAL, 1);
    step3(0, 0, 0, A, A, A, A, 3'b000, 0, 3'b100, DUAL, 0);

    // Five lanes: majority held away from lane 0, then lanes 3 and 4 mask together.
    step5(0, 0, B, A, A, A, C, A, 5'b10001, 0, 5'b00000, FULL, 0);
    for (int i = 0; i < 4; i++) step5(1, 0, A, A, A, B, C, A, 5'b11000, 0, 5'b00000, FULL, 0);
    step5(1, 0, A, A, A, A, A, A, 5'b00000, 0, 5'b11000, DEG, 1);
    step5(1, 0, A, A, A, A, A, A, 5'b00000, 0, 5'b11000, DEG, 0);
    step5(1, 0, A, B, C, A, A, A, 5'b00000, 1, 5'b11000, DEG, 0);
    step5(0, 0, A, A, A, A, A, A, 5'b00000, 0, 5'b11000, FLD, 0);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
